// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache that refills whole lines and answers only the latest fetch request
module icache_dm #(
    parameter int LINES = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_en,
    input  logic [29:0] icache_index,
    output logic [31:0] icache_rdata,
    output logic        icache_rvalid,
    input  logic        invalidate,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    localparam int OFF = $clog2(WORDS_PER_LINE);
    localparam int S = $clog2(LINES);
    localparam int T = 30 - OFF - S;
    typedef enum logic [1:0] {IDLE, MEM_REQ, REFILL, REPLAY} state_t;
    state_t state, state_n;
    logic [29:0] pend, look;
    logic [T+S-1:0] fill;
    logic [OFF-1:0] cnt;
    logic [LINES-1:0] valid;
    logic [T-1:0] tags [LINES];
    logic [31:0] data [LINES*WORDS_PER_LINE];
    logic inv_seen, lookup, hit, beat, last_beat;
    // a request arriving during REPLAY supersedes the pending one and is looked up directly
    assign look = (state == REPLAY && !icache_en) ? pend : icache_index;
    assign lookup = (state == IDLE && icache_en) || state == REPLAY;
    assign hit = lookup && !invalidate && valid[look[OFF+:S]] && tags[look[OFF+:S]] == look[29-:T];
    assign beat = state == REFILL && mem_resp_valid;
    assign last_beat = beat && &cnt;
    assign mem_req_valid = state == MEM_REQ;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = (icache_en && !hit) ? MEM_REQ : IDLE;
            MEM_REQ: state_n = mem_req_ready ? REFILL : MEM_REQ;
            REFILL:  state_n = last_beat ? REPLAY : REFILL;
            REPLAY:  state_n = hit ? IDLE : MEM_REQ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            icache_rvalid <= 1'b0;
            icache_rdata <= NOP_INSTR;
            mem_req_addr <= '0;
            pend <= '0;
            fill <= '0;
            cnt <= '0;
            inv_seen <= 1'b0;
        end else begin
            state <= state_n;
            icache_rvalid <= hit;
            if (hit) icache_rdata <= data[look[OFF+S-1:0]];
            if (icache_en) pend <= icache_index;
            if (state == MEM_REQ) cnt <= '0;
            else if (beat) cnt <= cnt + 1'b1;
            if (lookup && !hit) begin
                fill <= look[29:OFF];
                mem_req_addr <= {look[29:OFF], {(OFF+2){1'b0}}};
                inv_seen <= 1'b0;
            end else if ((state == MEM_REQ || state == REFILL) && invalidate) begin
                inv_seen <= 1'b1;
            end
            // a flush seen anywhere during the fill keeps the new line invalid
            if (invalidate) valid <= '0;
            else if (last_beat) valid[fill[S-1:0]] <= !inv_seen;
        end
    end
    always_ff @(posedge clk) begin
        if (beat && !rst) data[{fill[S-1:0], cnt}] <= mem_resp_data;
        if (last_beat && !rst) tags[fill[S-1:0]] <= fill[T+S-1:S];
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed test of icache_dm against a request-level model and a behavioural memory
module tb_icache_dm;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0, rst = 1'b1;
    logic icache_en = 1'b0, invalidate = 1'b0;
    logic [29:0] icache_index = '0;
    logic [31:0] icache_rdata, mem_req_addr, mem_resp_data;
    logic icache_rvalid, mem_req_valid, mem_req_ready, mem_resp_valid;
    int total = 0, bad = 0, nreq = 0, ver = 0, beat_no = -1;
    logic busy = 1'b0, armed = 1'b0, outstanding = 1'b0, answered = 1'b1;
    logic [29:0] lat = '0, base;
    logic [31:0] exp_hold = NOP, expv, last_addr = '0;
    logic [31:0] addr_hist [32];

    icache_dm dut (
        .clk(clk), .rst(rst), .icache_en(icache_en), .icache_index(icache_index),
        .icache_rdata(icache_rdata), .icache_rvalid(icache_rvalid), .invalidate(invalidate),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // memory image: every flush models fresh code being written, so contents change with ver
    function automatic logic [31:0] f(input logic [29:0] idx);
        return 32'hA0 + {2'b00, idx} + (32'(ver) << 24);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [29:0] idx);
        icache_en = 1'b1;
        icache_index = idx;
        step();
        icache_en = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        while (!answered && n < 60) begin
            step();
            n++;
        end
        total++;
        if (!answered) begin
            bad++;
            $display("FAIL %s: no rvalid after %0d cycles, want one", name, n);
        end
    endtask

    task automatic wait_beat(input int k);
        int n = 0;
        while (beat_no != k && n < 40) begin
            step();
            n++;
        end
        total++;
        if (beat_no != k) begin
            bad++;
            $display("FAIL wait_beat: got beat %0d want %0d", beat_no, k);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL mem_idle: responder still busy=%0d want 0", busy);
        end
    endtask

    task automatic pulse_inv();
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
    endtask

    // memory responder: accepts a line request (every other one after a wait cycle), then 4 beats with a gap
    initial begin
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_valid && !rst) begin
                busy = 1'b1;
                if (nreq % 2 == 1) begin
                    @(posedge clk);
                    #1;
                end
                mem_req_ready = 1'b1;
                base = mem_req_addr[31:2];
                last_addr = mem_req_addr;
                addr_hist[nreq%32] = mem_req_addr;
                @(posedge clk);
                #1;
                mem_req_ready = 1'b0;
                nreq++;
                for (int k = 0; k < 4; k++) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data = f(base + 30'(k));
                    beat_no = k;
                    @(posedge clk);
                    #1;
                    if (k == 1) begin
                        mem_resp_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                mem_resp_valid = 1'b0;
                beat_no = -1;
                busy = 1'b0;
            end
        end
    end

    // model: every rvalid answers the newest request issued in an earlier cycle, once, with current memory contents
    initial forever begin
        @(negedge clk);
        if (rst) begin
            outstanding = 1'b0;
            answered = 1'b1;
            exp_hold = NOP;
            armed = 1'b1;
        end else if (armed) begin
            total++;
            if (icache_rvalid) begin
                expv = f(lat);
                if (!outstanding || answered || icache_rdata !== expv) begin
                    bad++;
                    $display("FAIL rvalid: got rdata %h (outstanding=%0d answered=%0d) want %h for index %h",
                             icache_rdata, outstanding, answered, expv, lat);
                end
                answered = 1'b1;
                exp_hold = expv;
            end else if (icache_rdata !== exp_hold) begin
                bad++;
                $display("FAIL rdata_hold: got %h want %h", icache_rdata, exp_hold);
            end
            if (icache_en) begin
                lat = icache_index;
                outstanding = 1'b1;
                answered = 1'b0;
            end
            if (invalidate) ver++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        rst = 1'b0;
        check("reset_rvalid", {31'b0, icache_rvalid}, 32'd0);
        check("reset_rdata", icache_rdata, NOP);
        check("reset_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("reset_req_addr", mem_req_addr, 32'h0);
        req(30'h0);
        wait_resp("cold_miss");
        check("cold_rdata", icache_rdata, 32'hA0);
        check("cold_nreq", nreq, 1);
        check("cold_addr", last_addr, 32'h0);
        req(30'h1);
        req(30'h2);
        req(30'h3);
        check("b2b_rvalid", {31'b0, icache_rvalid}, 32'd1);
        check("b2b_rdata", icache_rdata, 32'hA3);
        wait_resp("b2b");
        check("b2b_nreq", nreq, 1);
        req(30'h100);
        wait_resp("conflict");
        check("conflict_addr", last_addr, 32'h400);
        check("conflict_rdata", icache_rdata, 32'h1A0);
        req(30'h0);
        wait_resp("conflict_back");
        check("conflict_back_nreq", nreq, 3);
        check("conflict_back_addr", last_addr, 32'h0);
        req(30'h10);
        wait_beat(1);
        req(30'h20);
        wait_resp("supersede");
        check("supersede_nreq", nreq, 5);
        check("supersede_addr0", addr_hist[3], 32'h40);
        check("supersede_addr1", last_addr, 32'h80);
        check("supersede_rdata", icache_rdata, 32'hC0);
        req(30'h13);
        wait_resp("superseded_line_hit");
        check("superseded_line_nreq", nreq, 5);
        check("superseded_line_rdata", icache_rdata, 32'hB3);
        pulse_inv();
        req(30'h0);
        wait_resp("inv_idle");
        check("inv_idle_nreq", nreq, 6);
        check("inv_idle_rdata", icache_rdata, 32'h0100_00A0);
        req(30'h40);
        wait_beat(1);
        pulse_inv();
        wait_resp("inv_refill");
        check("inv_refill_nreq", nreq, 8);
        check("inv_refill_addr", last_addr, 32'h100);
        check("inv_refill_rdata", icache_rdata, 32'h0200_00E0);
        wait_idle();
        req(30'h200);
        wait_beat(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_rvalid", {31'b0, icache_rvalid}, 32'd0);
        check("midrst_rdata", icache_rdata, NOP);
        check("midrst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("midrst_req_addr", mem_req_addr, 32'h0);
        wait_idle();
        check("midrst_beats_ignored", {31'b0, mem_req_valid}, 32'd0);
        req(30'h0);
        wait_resp("after_rst");
        check("after_rst_nreq", nreq, 10);
        check("after_rst_addr", last_addr, 32'h0);
        check("after_rst_rdata", icache_rdata, 32'h0200_00A0);
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
